// File: rtl/collatz_inv.sv
// collatz_inv: inverse Collatz walker. Consumes a reversed parity sequence one
// bit per handshake, walking back from 1 to rebuild the start value and the
// number of steps, and flags streams no start value could have produced.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   st                    start pulse: k=1, steps=0, enter RUN (any state)
//   bit_valid/bit_in      parity bit handshake (0 = inverse even, 1 = inverse odd)
//   bit_last              marks the final bit of the sequence
//   bit_ready             high while walking (RUN state)
//   k [W-1:0]             reconstructed value
//   steps [CW-1:0]        bits accepted since st
//   done / err / ovf      completion, illegal sequence, width overflow (levels)
module collatz_inv #(
  parameter int unsigned W  = 20,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st,
  input  logic          bit_valid,
  input  logic          bit_in,
  input  logic          bit_last,
  output logic          bit_ready,
  output logic [W-1:0]  k,
  output logic [CW-1:0] steps,
  output logic          done,
  output logic          err,
  output logic          ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  k_q, k_d;
  logic [CW-1:0] steps_q, steps_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  logic          accept_c;
  logic [W-1:0]  k_dbl_c;
  logic [W-1:0]  k_pred_c;
  logic          odd_ok_c;
  logic          illegal_odd_c;
  logic          k_big_c;
  logic          steps_sat_c;

  // Step datapath: doubling, and constant divide-by-3 / mod-6 for the odd predecessor.
  always_comb begin
    accept_c      = bit_valid && (state_q == S_RUN);
    k_dbl_c       = {k_q[W-2:0], 1'b0};
    k_pred_c      = (k_q - W'(1)) / W'(3);
    // k = 4 is excluded: its odd predecessor would be 1, where the forward walk stops.
    odd_ok_c      = ((k_q % W'(6)) == W'(4)) && (k_q != W'(4));
    illegal_odd_c = bit_in && !odd_ok_c;
    k_big_c       = !bit_in && k_q[W-1];
    steps_sat_c   = &steps_q;
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    steps_d = steps_q;
    done_d  = done_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    if (st) begin
      // Restart wins over a simultaneous handshake; that bit is dropped.
      state_d = S_RUN;
      k_d     = W'(1);
      steps_d = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ovf_d   = 1'b0;
    end else if (accept_c) begin
      if (illegal_odd_c || k_big_c || steps_sat_c) begin
        // Freeze k/steps at the last valid values; err and ovf can coincide.
        state_d = S_ERR;
        err_d   = illegal_odd_c;
        ovf_d   = k_big_c || steps_sat_c;
      end else begin
        k_d     = bit_in ? k_pred_c : k_dbl_c;
        steps_d = steps_q + CW'(1);
        if (bit_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= W'(1);
      steps_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      steps_q <= steps_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bit_ready = (state_q == S_RUN);
  assign k         = k_q;
  assign steps     = steps_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_collatz_inv.sv
// tb_collatz_inv: self-checking bench for collatz_inv with an arithmetic
// reference model; a second instance with a 4-bit step counter covers
// step-count saturation.
module tb_collatz_inv;

  localparam int unsigned W  = 20;
  localparam int unsigned CW = 16;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st, bit_valid, bit_in, bit_last;
  logic          bit_ready, done, err, ovf;
  logic [W-1:0]  k;
  logic [CW-1:0] steps;
  logic          bit_ready4, done4, err4, ovf4;
  logic [W-1:0]  k4;
  logic [3:0]    steps4;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int unsigned m_k, m_steps;
  int          m_st;
  bit          m_done, m_err, m_ovf;

  collatz_inv #(.W(W), .CW(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .st(st), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_last(bit_last), .bit_ready(bit_ready), .k(k), .steps(steps),
    .done(done), .err(err), .ovf(ovf)
  );

  collatz_inv #(.W(W), .CW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .st(st), .bit_valid(bit_valid), .bit_in(bit_in),
    .bit_last(bit_last), .bit_ready(bit_ready4), .k(k4), .steps(steps4),
    .done(done4), .err(err4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_k = 1; m_steps = 0; m_st = M_IDLE; m_done = 0; m_err = 0; m_ovf = 0;
  endtask

  // One rising edge of the abstract machine (16-bit step counter).
  task automatic model_edge(input bit s, input bit v, input bit b, input bit l);
    int unsigned nk, pred;
    bit big, bad, sat;
    if (s) begin
      m_k = 1; m_steps = 0; m_st = M_RUN; m_done = 0; m_err = 0; m_ovf = 0;
    end else if (v && m_st == M_RUN) begin
      big = 0; bad = 0;
      if (!b) begin
        nk  = m_k * 2;
        big = (nk >= (32'd1 << W));
      end else begin
        // predecessor must be an odd integer greater than 1
        pred = (m_k - 1) / 3;
        bad  = !(((m_k - 1) % 3 == 0) && (pred % 2 == 1) && (pred > 1));
        nk   = pred;
      end
      sat = (m_steps + 1 >= (32'd1 << CW));
      if (big || bad || sat) begin
        m_err = bad; m_ovf = big || sat; m_st = M_ERR;
      end else begin
        m_k = nk; m_steps = m_steps + 1;
        if (l) begin m_st = M_DONE; m_done = 1; end
      end
    end
  endtask

  function automatic logic [W+CW+3:0] exp_vec();
    return {W'(m_k), CW'(m_steps), m_done, m_err, m_ovf, (m_st == M_RUN)};
  endfunction

  function automatic logic [W+CW+3:0] obs_vec();
    return {k, steps, done, err, ovf, bit_ready};
  endfunction

  task automatic drive(input bit s, input bit v, input bit b, input bit l);
    st = s; bit_valid = v; bit_in = b; bit_last = l;
    @(posedge clk);
    model_edge(s, v, b, l);
    #1;
    st = 0; bit_valid = 0; bit_in = 0; bit_last = 0;
  endtask

  task automatic test_reset();
    checks++;
    if ({k, steps, done, err, ovf, bit_ready} !== {W'(1), CW'(0), 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: got %h exp %h", obs_vec(), {W'(1), CW'(0), 4'b0000});
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_trip_6();
    logic [W-1:0] exp_k [8] = '{2, 4, 8, 16, 5, 10, 3, 6};
    bit seq [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, seq[i], i == 7);
      checks++;
      if (k !== exp_k[i] || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL round_trip_6 bit%0d: got %h exp k=%0d vec %h", i, obs_vec(), exp_k[i], exp_vec());
      end
    end
    checks++;
    if ({k, steps, done, err, ovf, bit_ready} !== {W'(6), CW'(8), 4'b1000}) begin
      errors++;
      $display("FAIL round_trip_6 final: got %h exp k=6 steps=8 done=1", obs_vec());
    end
  endtask

  task automatic test_illegal_odd();
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 0);
    checks++;
    if ({k, steps, done, err, ovf, bit_ready} !== {W'(1), CW'(0), 4'b0100} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL illegal_odd_k1: got %h exp k=1 steps=0 err=1", obs_vec());
    end
    drive(0, 1, 0, 0); // ignored in ERR
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL err_holds: got %h exp %h", obs_vec(), exp_vec());
    end
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 1); // last and illegal -> ERR, never DONE
    checks++;
    if ({k, steps, done, err, ovf, bit_ready} !== {W'(4), CW'(2), 4'b0100} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL illegal_odd_k4: got %h exp k=4 steps=2 err=1", obs_vec());
    end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 19; i++) drive(0, 1, 0, 0);
    checks++;
    if ({k, steps, ovf} !== {W'(524288), CW'(19), 1'b0}) begin
      errors++;
      $display("FAIL overflow_pre: got k=%0d steps=%0d ovf=%b exp 524288/19/0", k, steps, ovf);
    end
    drive(0, 1, 0, 0);
    checks++;
    if ({k, steps, done, err, ovf, bit_ready} !== {W'(524288), CW'(19), 4'b0010} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL overflow_k: got %h exp k=524288 steps=19 ovf=1", obs_vec());
    end
  endtask

  task automatic test_backpressure();
    bit seq [8] = '{0, 0, 0, 0, 1, 0, 1, 0};
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, seq[i], i == 7);
      for (int g = 0; g < 3 && i < 7; g++) begin
        drive(0, 0, ~seq[i], 1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL backpressure gap%0d.%0d: got %h exp %h", i, g, obs_vec(), exp_vec());
        end
      end
    end
    checks++;
    if ({k, steps, done, err, ovf} !== {W'(6), CW'(8), 3'b100}) begin
      errors++;
      $display("FAIL backpressure final: got %h exp k=6 steps=8 done=1", obs_vec());
    end
  endtask

  task automatic test_restart_reset();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
    checks++;
    if (k !== W'(16)) begin
      errors++;
      $display("FAIL restart_pre: got k=%0d exp 16", k);
    end
    drive(1, 1, 1, 0); // bit dropped
    checks++;
    if ({k, steps, done, err, ovf, bit_ready} !== {W'(1), CW'(0), 4'b0001} || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL restart_mid: got %h exp k=1 steps=0 run", obs_vec());
    end
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({k, steps, done, err, ovf, bit_ready} !== {W'(1), CW'(0), 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: got %h exp k=1 steps=0 flags=0", obs_vec());
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 0);
    checks++;
    if ({k4, steps4, ovf4, bit_ready4} !== {W'(32768), 4'd15, 2'b01}) begin
      errors++;
      $display("FAIL saturation_pre: got k=%0d steps=%0d ovf=%b exp 32768/15/0", k4, steps4, ovf4);
    end
    drive(0, 1, 0, 0);
    checks++;
    if ({k4, steps4, done4, err4, ovf4, bit_ready4} !== {W'(32768), 4'd15, 4'b0010}) begin
      errors++;
      $display("FAIL saturation: got k=%0d steps=%0d d/e/o/r=%b%b%b%b exp 32768/15 ovf", k4, steps4, done4, err4, ovf4, bit_ready4);
    end
  endtask

  // Random start values: compute the forward parity walk, feed it reversed.
  task automatic test_random_round_trip();
    for (int t = 0; t < 25; t++) begin
      int unsigned n, v;
      bit par[$];
      n = $urandom_range(999, 2);
      v = n;
      par.delete();
      while (v != 1) begin
        if (v % 2 == 0) begin par.push_back(0); v = v / 2; end
        else            begin par.push_back(1); v = 3 * v + 1; end
      end
      drive(1, 0, 0, 0);
      for (int i = par.size() - 1; i >= 0; i--) begin
        while ($urandom_range(3, 0) == 0) drive(0, 0, 1, 1);
        drive(0, 1, par[i], i == 0);
      end
      checks++;
      if ({k, steps, done, err, ovf, bit_ready} !== {W'(n), CW'(par.size()), 4'b1000} || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_round_trip n=%0d: got %h exp k=%0d steps=%0d done", n, obs_vec(), n, par.size());
      end
    end
  endtask

  // Random bit streams, including illegal ones and random restarts.
  task automatic test_random_bits();
    for (int c = 0; c < 400; c++) begin
      bit s, v, b, l;
      s = (m_st != M_RUN) ? ($urandom_range(2, 0) == 0) : ($urandom_range(30, 0) == 0);
      v = ($urandom_range(9, 0) < 7);
      b = ($urandom_range(9, 0) < 3);
      l = ($urandom_range(9, 0) == 0);
      drive(s, v, b, l);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_bits cyc%0d: got %h exp %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; st = 0; bit_valid = 0; bit_in = 0; bit_last = 0;
    model_reset();
    #12;
    test_reset();
    test_round_trip_6();
    test_illegal_odd();
    test_overflow();
    test_backpressure();
    test_restart_reset();
    test_saturation();
    test_random_round_trip();
    test_random_bits();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
